io_terminal: RTL and testbench

Peripheral side of the basic computer's I/O instruction protocol: it owns INPR, OUTR, FGI, FGO and IEN, and answers the single-cycle strobes that control_unit produces for INP, OUT, SKI, SKO, ION and IOF. Keyboard characters arrive over a parallel valid/ready handshake. Printer characters leave on an 8N1 serial line. The block sits between control_unit/AC and the external terminal, and raises the interrupt request that control_unit samples to enter the interrupt cycle.

---
 rtl/io_terminal.sv | 164 ++++++++++++++++
 tb/tb_io_terminal.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_terminal.sv
`default_nettype none
// ============================================================================
// Module   : io_terminal
// Purpose  : INPR/OUTR/FGI/FGO/IEN owner for the basic computer I/O
//            instructions, with a keyboard handshake and an 8N1 printer line.
// Revision : 1.0  initial release
// ============================================================================
module io_terminal #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_inp,
    input  logic       io_out,
    input  logic       io_ski,
    input  logic       io_sko,
    input  logic       io_ion,
    input  logic       io_iof,
    input  logic       io_int_ack,
    input  logic [7:0] ac_low,
    output logic [7:0] inpr,
    output logic       fgi,
    output logic       fgo,
    output logic       ien,
    output logic       skip,
    output logic       irq,
    input  logic       kbd_valid,
    input  logic [7:0] kbd_data,
    output logic       kbd_ready,
    output logic       tx
);

    localparam int                  c_TICK_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_TICK_W-1:0] w_tick_nxt;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          r_outr;
    logic [7:0]          r_inpr;
    logic                r_fgi;
    logic                r_fgo;
    logic                r_ien;

    logic w_accept;
    logic w_out_go;
    logic w_tick_end;
    logic w_frame_done;
    logic w_tx;

    assign w_accept   = kbd_valid & ~r_fgi;
    // fgo=1 only while the transmitter is idle, so it alone gates a new frame
    assign w_out_go   = io_out & r_fgo;
    assign w_tick_end = (r_tick == c_TICK_MAX);

    // Transmitter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_tick  <= '0;
            r_bit   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // Transmitter next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick + 1'b1;
        w_bit_nxt   = r_bit;
        case (r_state)
            c_S_IDLE: begin
                w_tick_nxt = '0;
                if (w_out_go) w_state_nxt = c_S_START;
            end
            c_S_START: begin
                if (w_tick_end) begin
                    w_state_nxt = c_S_DATA;
                    w_tick_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                end
            end
            c_S_DATA: begin
                if (w_tick_end) begin
                    w_tick_nxt = '0;
                    w_bit_nxt  = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nxt = c_S_STOP;
                end
            end
            c_S_STOP: begin
                if (w_tick_end) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_tick_nxt  = '0;
            end
        endcase
    end

    // Transmitter outputs
    always_comb begin
        w_tx         = 1'b1;
        w_frame_done = 1'b0;
        case (r_state)
            c_S_START: w_tx = 1'b0;
            c_S_DATA:  w_tx = r_outr[r_bit];
            c_S_STOP:  w_frame_done = w_tick_end;
            default:   w_tx = 1'b1;
        endcase
    end

    // Registers and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inpr <= 8'h00;
            r_outr <= 8'h00;
            r_fgi  <= 1'b0;
            r_fgo  <= 1'b1;
            r_ien  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_inpr <= kbd_data;
                r_fgi  <= 1'b1;
            end else if (io_inp) begin
                r_fgi  <= 1'b0;
            end

            if (w_out_go) begin
                r_outr <= ac_low;
                r_fgo  <= 1'b0;
            end else if (w_frame_done) begin
                r_fgo  <= 1'b1;
            end

            if (io_iof | io_int_ack) r_ien <= 1'b0;
            else if (io_ion)         r_ien <= 1'b1;
        end
    end

    assign inpr      = r_inpr;
    assign fgi       = r_fgi;
    assign fgo       = r_fgo;
    assign ien       = r_ien;
    assign kbd_ready = ~r_fgi;
    assign skip      = (io_ski & r_fgi) | (io_sko & r_fgo);
    assign irq       = r_ien & (r_fgi | r_fgo);
    assign tx        = w_tx;

endmodule
`default_nettype wire

// File: tb/tb_io_terminal.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_terminal
// Purpose  : Table vectors, frame sequences and random stimulus for
//            io_terminal, checked against a cycle-count reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_terminal;

    localparam int c_C = 4;

    typedef struct packed {
        logic       rst;
        logic       kv;
        logic [7:0] kd;
        logic       inp;
        logic       out;
        logic       ski;
        logic       sko;
        logic       ion;
        logic       iof;
        logic       ack;
        logic [7:0] ac;
    } in_t;

    typedef struct packed {
        logic [7:0] inpr;
        logic       fgi;
        logic       fgo;
        logic       ien;
        logic       skip;
        logic       irq;
        logic       rdy;
        logic       tx;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, io_inp, io_out, io_ski, io_sko, io_ion, io_iof, io_int_ack;
    logic [7:0] ac_low, inpr, kbd_data;
    logic       fgi, fgo, ien, skip, irq, kbd_valid, kbd_ready, tx;

    always #5 clk = ~clk;

    io_terminal #(.CLKS_PER_BIT(c_C)) dut (
        .clk(clk), .rst(rst), .io_inp(io_inp), .io_out(io_out),
        .io_ski(io_ski), .io_sko(io_sko), .io_ion(io_ion), .io_iof(io_iof),
        .io_int_ack(io_int_ack), .ac_low(ac_low), .inpr(inpr), .fgi(fgi),
        .fgo(fgo), .ien(ien), .skip(skip), .irq(irq), .kbd_valid(kbd_valid),
        .kbd_data(kbd_data), .kbd_ready(kbd_ready), .tx(tx)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;
    out_t obs;

    // Reference model: flags plus "cycles since frame start"
    logic [7:0] m_inpr, m_outr;
    logic       m_fgi, m_fgo, m_ien, m_busy;
    int         m_t;

    function automatic in_t iv(logic kv, logic [7:0] kd, logic inp, logic out,
                               logic ski, logic sko, logic ion, logic iof,
                               logic ack, logic [7:0] ac);
        iv = '{rst:1'b0, kv:kv, kd:kd, inp:inp, out:out, ski:ski, sko:sko,
               ion:ion, iof:iof, ack:ack, ac:ac};
    endfunction

    function automatic out_t ov(logic [7:0] i, logic fi, logic fo, logic ie,
                                logic sk, logic iq, logic rd, logic t);
        ov = '{inpr:i, fgi:fi, fgo:fo, ien:ie, skip:sk, irq:iq, rdy:rd, tx:t};
    endfunction

    function automatic logic frame_bit(logic [7:0] b, int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    function automatic logic model_tx();
        if (!m_busy) return 1'b1;
        if (m_t < c_C) return 1'b0;
        if (m_t < 9 * c_C) return m_outr[m_t / c_C - 1];
        return 1'b1;
    endfunction

    function automatic out_t model_out(in_t vi);
        model_out = ov(m_inpr, m_fgi, m_fgo, m_ien,
                       (vi.ski & m_fgi) | (vi.sko & m_fgo),
                       m_ien & (m_fgi | m_fgo), ~m_fgi, model_tx());
    endfunction

    task automatic model_step(in_t vi);
        if (vi.rst) begin
            m_inpr = 8'h00; m_outr = 8'h00; m_fgi = 1'b0; m_fgo = 1'b1;
            m_ien = 1'b0; m_busy = 1'b0; m_t = 0;
        end else begin
            if (vi.kv && !m_fgi) begin
                m_inpr = vi.kd;
                m_fgi  = 1'b1;
            end else if (vi.inp) begin
                m_fgi = 1'b0;
            end
            if (m_busy) begin
                m_t = m_t + 1;
                if (m_t == 10 * c_C) begin
                    m_busy = 1'b0;
                    m_fgo  = 1'b1;
                end
            end else if (vi.out && m_fgo) begin
                m_busy = 1'b1; m_t = 0; m_outr = vi.ac; m_fgo = 1'b0;
            end
            if (vi.iof || vi.ack) m_ien = 1'b0;
            else if (vi.ion)      m_ien = 1'b1;
        end
    endtask

    task automatic chk(string nm, logic [14:0] act, logic [14:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // One clock: drive, compare against the model mid-cycle, then advance
    task automatic run(in_t vi);
        out_t e;
        rst = vi.rst; kbd_valid = vi.kv; kbd_data = vi.kd; io_inp = vi.inp;
        io_out = vi.out; io_ski = vi.ski; io_sko = vi.sko; io_ion = vi.ion;
        io_iof = vi.iof; io_int_ack = vi.ack; ac_low = vi.ac;
        @(negedge clk);
        obs = {inpr, fgi, fgo, ien, skip, irq, kbd_ready, tx};
        e   = model_out(vi);
        if (chk_en) chk("model", obs, e);
        @(posedge clk);
        model_step(vi);
        #1;
    endtask

    in_t  idle, vi;
    vec_t tbl[17];

    initial begin
        idle = iv(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        //            kv kd     inp out ski sko ion iof ack ac      inpr  fgi fgo ien sk iq rd tx
        tbl[0]  = '{iv(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00), ov(8'h00, 0, 1, 0, 0, 0, 1, 1)};
        tbl[1]  = '{iv(1, 8'h41, 0, 0, 0, 0, 0, 0, 0, 8'h00), ov(8'h00, 0, 1, 0, 0, 0, 1, 1)};
        tbl[2]  = '{iv(1, 8'h42, 0, 0, 1, 0, 0, 0, 0, 8'h00), ov(8'h41, 1, 1, 0, 1, 0, 0, 1)};
        tbl[3]  = '{iv(1, 8'h42, 0, 0, 0, 0, 0, 0, 0, 8'h00), ov(8'h41, 1, 1, 0, 0, 0, 0, 1)};
        tbl[4]  = '{iv(1, 8'h42, 1, 0, 0, 0, 0, 0, 0, 8'h00), ov(8'h41, 1, 1, 0, 0, 0, 0, 1)};
        tbl[5]  = '{iv(1, 8'h42, 0, 0, 0, 0, 0, 0, 0, 8'h00), ov(8'h41, 0, 1, 0, 0, 0, 1, 1)};
        tbl[6]  = '{iv(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00), ov(8'h42, 1, 1, 0, 0, 0, 0, 1)};
        tbl[7]  = '{iv(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00), ov(8'h42, 1, 1, 1, 0, 1, 0, 1)};
        tbl[8]  = '{iv(0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h00), ov(8'h42, 1, 1, 1, 0, 1, 0, 1)};
        tbl[9]  = '{iv(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00), ov(8'h42, 1, 1, 0, 0, 0, 0, 1)};
        tbl[10] = '{iv(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00), ov(8'h42, 1, 1, 0, 0, 0, 0, 1)};
        tbl[11] = '{iv(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h00), ov(8'h42, 1, 1, 1, 0, 1, 0, 1)};
        tbl[12] = '{iv(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00), ov(8'h42, 1, 1, 0, 0, 0, 0, 1)};
        tbl[13] = '{iv(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 8'h00), ov(8'h42, 1, 1, 0, 1, 0, 0, 1)};
        tbl[14] = '{iv(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00), ov(8'h42, 0, 1, 0, 0, 0, 1, 1)};
        tbl[15] = '{iv(1, 8'h55, 1, 0, 0, 0, 0, 0, 0, 8'h00), ov(8'h42, 0, 1, 0, 0, 0, 1, 1)};
        tbl[16] = '{iv(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00), ov(8'h55, 1, 1, 0, 0, 0, 0, 1)};

        vi = idle; vi.rst = 1'b1;
        run(vi);
        run(vi);
        chk_en = 1'b1;

        foreach (tbl[n]) begin
            run(tbl[n].i);
            chk($sformatf("table[%0d]", n), obs, tbl[n].e);
        end

        // 0xA5 frame with an ignored OUT of 0xFF at cycle 8
        vi = idle; vi.out = 1'b1; vi.ac = 8'hA5;
        run(vi);
        for (int j = 0; j <= 40; j++) begin
            vi = idle;
            if (j == 8)  begin vi.out = 1'b1; vi.ac = 8'hFF; end
            if (j == 40) vi.sko = 1'b1;
            run(vi);
            if (j < 40 && (j % c_C) == 1)
                chk($sformatf("a5_bit%0d", j / c_C), 15'(obs.tx),
                    15'(frame_bit(8'hA5, j / c_C)));
            if (j == 39) chk("a5_fgo_busy", 15'(obs.fgo), 15'd0);
            if (j == 40) chk("a5_fgo_skip", {13'd0, obs.fgo, obs.skip}, 15'b11);
        end
        for (int j = 0; j < 12; j++) begin
            run(idle);
            chk("no_second_frame", 15'(obs.tx), 15'd1);
        end

        // Reset during data bit 3, then a clean 0x0F frame
        vi = idle; vi.out = 1'b1; vi.ac = 8'h3C;
        run(vi);
        for (int j = 0; j < 4 * c_C; j++) run(idle);
        vi = idle; vi.rst = 1'b1;
        run(vi);
        run(idle);
        chk("rst_mid_frame", {13'd0, obs.tx, obs.fgo}, 15'b11);
        vi = idle; vi.out = 1'b1; vi.ac = 8'h0F;
        run(vi);
        for (int j = 0; j < 10 * c_C; j++) begin
            run(idle);
            if ((j % c_C) == 2)
                chk($sformatf("0f_bit%0d", j / c_C), 15'(obs.tx),
                    15'(frame_bit(8'h0F, j / c_C)));
        end
        run(idle);
        chk("0f_fgo_back", 15'(obs.fgo), 15'd1);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            vi.rst = ($urandom_range(0, 399) == 0);
            vi.kv  = ($urandom_range(0, 3) == 0);
            vi.kd  = 8'($urandom);
            vi.inp = ($urandom_range(0, 7) == 0);
            vi.out = ($urandom_range(0, 9) == 0);
            vi.ski = ($urandom_range(0, 3) == 0);
            vi.sko = ($urandom_range(0, 3) == 0);
            vi.ion = ($urandom_range(0, 7) == 0);
            vi.iof = ($urandom_range(0, 15) == 0);
            vi.ack = ($urandom_range(0, 15) == 0);
            vi.ac  = 8'($urandom);
            run(vi);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
